// File: rtl/awgn_rx_demod.sv
// BPSK-over-AWGN receive path: modulate, add noise, saturate, hard-decide, then
// track per-window bit errors to drive a GOOD/BAD channel estimate.
module awgn_rx_demod #(
  parameter logic signed [15:0] AMP      = 16'sd8192,
  parameter int                 WIN      = 64,
  parameter int                 BAD_THR  = 8,
  parameter int                 GOOD_THR = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_bit,
  input  logic signed [15:0] noise,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_sample,
  output logic               out_bit,
  output logic               out_err,
  input  logic               clr,
  output logic               est_state,
  output logic               win_done,
  output logic [31:0]        bit_cnt,
  output logic [31:0]        err_cnt
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int ERR_W  = CNT_W + 1;

  localparam logic signed [DATA_W:0] SAT_MAX  = 17'sd32767;
  localparam logic signed [DATA_W:0] SAT_MIN  = -17'sd32768;
  localparam logic [CNT_W-1:0]       WIN_LAST = CNT_W'(WIN - 1);
  localparam logic [ERR_W-1:0]       BAD_T    = ERR_W'(BAD_THR);
  localparam logic [ERR_W-1:0]       GOOD_T   = ERR_W'(GOOD_THR);

  typedef enum logic {EST_BAD = 1'b0, EST_GOOD = 1'b1} est_t;

  function automatic logic signed [DATA_W-1:0] sat_sample(input logic signed [DATA_W:0] x);
    if (x > SAT_MAX)      return 16'sh7fff;
    else if (x < SAT_MIN) return 16'sh8000;
    else                  return x[DATA_W-1:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic                     vld_p1, vld_p2;
  logic signed [DATA_W-1:0] sum_p1, sample_p2;
  logic                     bit_p1, bit_p2, err_p2;
  logic                     s1_advance, in_fire, out_fire;
  logic signed [DATA_W-1:0] amp_sel;
  logic signed [DATA_W:0]   sum_ext;
  logic [CNT_W-1:0]         win_cnt;
  logic [ERR_W-1:0]         win_err, win_final;
  est_t                     est;

  assign s1_advance = !vld_p2 || out_ready;
  assign in_ready   = !vld_p1 || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = vld_p2 && out_ready;

  assign amp_sel = in_bit ? AMP : -AMP;
  assign sum_ext = $signed({amp_sel[DATA_W-1], amp_sel}) + $signed({noise[DATA_W-1], noise});

  // Stage 1: noisy symbol, saturated to the output range
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      sum_p1 <= '0;
      bit_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_fire) begin
        sum_p1 <= sat_sample(sum_ext);
        bit_p1 <= in_bit;
      end
    end
  end

  // Stage 2: hard decision; zero decides 1 so only the sign bit matters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2    <= 1'b0;
      sample_p2 <= '0;
      bit_p2    <= 1'b0;
      err_p2    <= 1'b0;
    end else if (s1_advance) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sample_p2 <= sum_p1;
        bit_p2    <= ~sum_p1[DATA_W-1];
        err_p2    <= ~sum_p1[DATA_W-1] ^ bit_p1;
      end
    end
  end

  assign out_valid  = vld_p2;
  assign out_sample = sample_p2;
  assign out_bit    = bit_p2;
  assign out_err    = err_p2;

  // Window tally includes the symbol transferring now, so the close sees the full count
  assign win_final = win_err + ERR_W'(err_p2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      win_err  <= '0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      win_done <= 1'b0;
      est      <= EST_GOOD;
    end else if (clr) begin
      win_cnt  <= '0;
      win_err  <= '0;
      bit_cnt  <= '0;
      err_cnt  <= '0;
      win_done <= 1'b0;
      est      <= EST_GOOD;
    end else begin
      win_done <= 1'b0;
      if (out_fire) begin
        bit_cnt <= sat_inc(bit_cnt);
        if (err_p2) err_cnt <= sat_inc(err_cnt);
        if (win_cnt == WIN_LAST) begin
          win_cnt  <= '0;
          win_err  <= '0;
          win_done <= 1'b1;
          case (est)
            EST_GOOD: if (win_final >= BAD_T)  est <= EST_BAD;
            EST_BAD:  if (win_final <= GOOD_T) est <= EST_GOOD;
            default:  est <= EST_GOOD;
          endcase
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_err <= win_final;
        end
      end
    end
  end

  assign est_state = est;

endmodule

// File: doc/awgn_rx_demod.md
AWGN_RX_DEMOD -- requirements
Module: awgn_rx_demod

Interface
REQ-001 Parameter AMP, default 16'sd8192, SHALL set the BPSK symbol amplitude (bit 1 -> +AMP, bit 0 -> -AMP).
REQ-002 Parameter WIN, default 64, SHALL set the channel-estimation window length in output symbols (power of two, 2..1024).
REQ-003 Parameter BAD_THR, default 8, SHALL set the window error count at or above which the estimate goes BAD.
REQ-004 Parameter GOOD_THR, default 2, SHALL set the window error count at or below which the estimate returns GOOD.
REQ-005 clk  input  1  sole clock; all logic SHALL be rising-edge triggered.
REQ-006 rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-007 in_valid  input  1  input symbol valid.
REQ-008 in_ready  output  1  block accepts the input symbol this cycle.
REQ-009 in_bit  input  1  transmitted bit, used as the error reference.
REQ-010 noise  input  16  signed noise sample from the channel noise source.
REQ-011 out_valid  output  1  output symbol valid.
REQ-012 out_ready  input  1  downstream accepts the output symbol.
REQ-013 out_sample  output  16  signed, saturated received sample.
REQ-014 out_bit  output  1  hard decision.
REQ-015 out_err  output  1  out_bit differs from the transmitted bit.
REQ-016 clr  input  1  synchronous clear of statistics and estimator.
REQ-017 est_state  output  1  channel estimate: 1 = GOOD, 0 = BAD (same encoding as the channel state input).
REQ-018 win_done  output  1  one-cycle pulse when a window closes.
REQ-019 bit_cnt  output  32  total symbols delivered on the output handshake.
REQ-020 err_cnt  output  32  total delivered symbols with out_err=1.

Function
REQ-021 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-022 Stage 1 SHALL register sum = (in_bit ? AMP : -AMP) + noise using 17-bit arithmetic, saturated to [-32768, +32767], together with in_bit.
REQ-023 Stage 2 SHALL register out_sample = sum, out_bit = (sum >= 0), and out_err = out_bit ^ in_bit; a sum of exactly 0 SHALL decide 1.
REQ-024 Latency SHALL be 2 cycles from the input transfer to out_valid when there is no backpressure.
REQ-025 Stage 2 SHALL hold all of its outputs while out_valid && !out_ready.
REQ-026 Stage 1 SHALL advance when stage 2 is empty or out_ready=1.
REQ-027 in_ready SHALL equal !s1_valid || s1_advance.
REQ-028 Throughput SHALL be 1 symbol/cycle, and no symbol SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-029 win_cnt SHALL count output transfers; win_err SHALL count output transfers with out_err=1, including the transfer that closes the window.
REQ-030 On the output transfer where win_cnt reaches WIN-1, the block SHALL evaluate the estimator FSM, pulse win_done on the next cycle, and restart win_cnt and win_err at 0.
REQ-031 FSM GOOD SHALL go to BAD if the final window error count >= BAD_THR; otherwise it SHALL stay GOOD.
REQ-032 FSM BAD SHALL go to GOOD if the final window error count <= GOOD_THR; otherwise it SHALL stay BAD.
REQ-033 est_state SHALL be registered and SHALL change only in the cycle win_done is asserted.
REQ-034 bit_cnt and err_cnt SHALL saturate at 32'hFFFFFFFF, not wrap.
REQ-035 clr=1 SHALL, on the next edge, zero win_cnt, win_err, bit_cnt and err_cnt, set the FSM to GOOD, and suppress win_done.
REQ-036 clr SHALL win over a simultaneous window close and over counter increments.
REQ-037 clr SHALL NOT affect the datapath pipeline or the handshakes.

Reset
REQ-038 While rst_n=0, the block SHALL asynchronously force s1_valid=0, out_valid=0, out_sample=0, out_bit=0, out_err=0, in_ready=1, est_state=1 (GOOD), win_done=0, bit_cnt=0, err_cnt=0, win_cnt=0 and win_err=0.
REQ-039 Reset asserted mid-operation SHALL discard in-flight symbols, with no output transfer occurring in the cycle after reset release.

Verification
REQ-040 Bench SHALL drive in_bit=1, noise=0, out_ready=1 and check out_sample=8192, out_bit=1, out_err=0, two cycles after the input transfer.
REQ-041 Bench SHALL drive in_bit=1, noise=16'sd32000 and check out_sample=32767 (saturated); it SHALL drive in_bit=0, noise=-32000 and check out_sample=-32768.
REQ-042 Bench SHALL drive in_bit=1, noise=-8192 and check out_sample=0, out_bit=1; it SHALL drive noise=-8193 and check out_bit=0, out_err=1.
REQ-043 Bench SHALL stream 100 symbols with random out_ready (50%) and check that the output order and values match a reference model, with no loss or duplication.
REQ-044 Bench SHALL drive a window of 64 symbols with 8 errors and check win_done and est_state 1->0; it SHALL then drive 64 symbols with 3 errors and check est_state stays 0; it SHALL then drive 64 symbols with 2 errors and check est_state 0->1.
REQ-045 Bench SHALL assert clr on the cycle of the 64th output transfer and check win_done=0, bit_cnt=0, err_cnt=0, est_state=1.
